// File: rtl/stream_demux2.sv
// Steers one valid/ready stream to channel A or B in grant bursts of up to HOLD beats; one-entry output register per channel.
// One cycle from input beat to output valid; input stalls while the granted channel's register is full and not being drained.
module stream_demux2 #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fa,
  input  logic             fb,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic             sel,
  output logic             busy
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {IDLE, ROUTE_A, ROUTE_B} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_b;
  logic          acc;
  logic          a_done;
  logic          b_done;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      ROUTE_A: in_ready = (cnt < HOLD_C) && fa && (!out_a_valid || out_a_ready);
      ROUTE_B: in_ready = (cnt < HOLD_C) && fb && (!out_b_valid || out_b_ready);
      default: in_ready = 1'b0;
    endcase
  end

  assign acc = in_valid & in_ready;

  // Leave a route only once the burst is over and the output register is empty or emptying.
  assign a_done = ((cnt == HOLD_C) || !fa) && !acc && (!out_a_valid || out_a_ready);
  assign b_done = ((cnt == HOLD_C) || !fb) && !acc && (!out_b_valid || out_b_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_a_valid <= 1'b0;
      out_b_valid <= 1'b0;
      out_a_data  <= '0;
      out_b_data  <= '0;
      sel         <= 1'b0;
      busy        <= 1'b0;
      last_b      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fa && (!fb || last_b)) begin
            state  <= ROUTE_A;
            sel    <= 1'b0;
            last_b <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
          end else if (fb) begin
            state  <= ROUTE_B;
            sel    <= 1'b1;
            last_b <= 1'b1;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        ROUTE_A: begin
          if (acc) begin
            out_a_data  <= in_data;
            out_a_valid <= 1'b1;
            cnt         <= cnt + ONE_C;
          end else if (out_a_valid && out_a_ready) begin
            out_a_valid <= 1'b0;
          end
          if (a_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ROUTE_B: begin
          if (acc) begin
            out_b_data  <= in_data;
            out_b_valid <= 1'b1;
            cnt         <= cnt + ONE_C;
          end else if (out_b_valid && out_b_ready) begin
            out_b_valid <= 1'b0;
          end
          if (b_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
